// File: rtl/ws2812_pkg.sv
// Shared types for the WS2812 pixel serializer.
// Build option: define WS2812_RGBW_EN for 32-bit GRBW (SK6812) pixels; 24-bit GRB otherwise.
package ws2812_pkg;

`ifdef WS2812_RGBW_EN
    localparam int unsigned PIX_BITS = 32;
`else
    localparam int unsigned PIX_BITS = 24;
`endif

    // Bit index is wide enough for both the 24- and 32-bit pixel formats
    localparam int unsigned IDX_BITS = 5;

    typedef logic [PIX_BITS-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        WAIT  = 2'd2,
        LATCH = 2'd3
    } ser_state_t;

endpackage

// File: rtl/ws2812_pixel_serializer.sv
// Serializes pixel words MSB-first into one-bit-at-a-time requests for the WS2812 bit coder,
// then holds the line low for a programmable latch period and pulses frame_done_out.
// Build option: WS2812_RGBW_EN selects 32-bit GRBW pixels (see ws2812_pkg).
module ws2812_pixel_serializer
    import ws2812_pkg::*;
#(
    parameter int unsigned RST_CNT_WIDTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     pix_valid_in,
    output logic                     pix_ready_out,
    input  logic [PIX_BITS-1:0]      pix_data_in,
    input  logic                     pix_last_in,
    input  logic [RST_CNT_WIDTH-1:0] rst_cnt_in,
    input  logic                     bit_done_in,
    output logic                     bit_rdy_out,
    output logic                     bit_data_out,
    output logic                     busy_out,
    output logic                     frame_done_out
);

    ser_state_t               state_q;
    pix_t                     shift_q;
    logic [IDX_BITS-1:0]      idx_q;
    logic                     last_q;
    logic [RST_CNT_WIDTH-1:0] cnt_q;

    // Serializer FSM; every output is set on the transition into the state that owns it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            idx_q          <= '0;
            last_q         <= 1'b0;
            cnt_q          <= '0;
            pix_ready_out  <= 1'b1;
            bit_rdy_out    <= 1'b0;
            bit_data_out   <= 1'b0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            bit_rdy_out    <= 1'b0;
            frame_done_out <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // ready is high throughout IDLE, so valid alone completes the handshake
                    if (pix_valid_in) begin
                        shift_q       <= pix_data_in;
                        idx_q         <= IDX_BITS'(PIX_BITS - 1);
                        last_q        <= pix_last_in;
                        bit_data_out  <= pix_data_in[PIX_BITS-1];
                        bit_rdy_out   <= 1'b1;
                        pix_ready_out <= 1'b0;
                        busy_out      <= 1'b1;
                        state_q       <= SEND;
                    end
                end
                SEND: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // bit_data_out is left untouched until the coder reports the bit done
                    if (bit_done_in) begin
                        if (idx_q != '0) begin
                            shift_q      <= shift_q << 1;
                            idx_q        <= idx_q - IDX_BITS'(1);
                            bit_data_out <= shift_q[PIX_BITS-2];
                            bit_rdy_out  <= 1'b1;
                            state_q      <= SEND;
                        end else if (last_q) begin
                            cnt_q        <= rst_cnt_in;
                            bit_data_out <= 1'b0;
                            state_q      <= LATCH;
                        end else begin
                            bit_data_out  <= 1'b0;
                            pix_ready_out <= 1'b1;
                            busy_out      <= 1'b0;
                            state_q       <= IDLE;
                        end
                    end
                end
                LATCH: begin
                    // count sampled on entry only, so the period is rst_cnt_in+1 cycles
                    if (cnt_q == '0) begin
                        frame_done_out <= 1'b1;
                        pix_ready_out  <= 1'b1;
                        busy_out       <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - RST_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    pix_ready_out <= 1'b1;
                    busy_out      <= 1'b0;
                    bit_data_out  <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Self-checking bench for ws2812_pixel_serializer: a timeline model of the serializer plus a
// coder model answering each bit request after a configurable delay.
module tb_ws2812_pixel_serializer;

    localparam int unsigned PB  = ws2812_pkg::PIX_BITS;
    localparam int unsigned RCW = 16;

`ifdef WS2812_RGBW_EN
    localparam logic [PB-1:0] DIR_PIX = PB'(32'hDEADBEEF);
`else
    localparam logic [PB-1:0] DIR_PIX = PB'(24'hA50F81);
`endif

    typedef struct {
        logic [PB-1:0] data;
        logic          last;
    } stim_t;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic           pix_valid_in;
    logic           pix_ready_out;
    logic [PB-1:0]  pix_data_in;
    logic           pix_last_in;
    logic [RCW-1:0] rst_cnt_in;
    logic           bit_done_in;
    logic           bit_rdy_out;
    logic           bit_data_out;
    logic           busy_out;
    logic           frame_done_out;

    ws2812_pixel_serializer #(.RST_CNT_WIDTH(RCW)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .pix_valid_in   (pix_valid_in),
        .pix_ready_out  (pix_ready_out),
        .pix_data_in    (pix_data_in),
        .pix_last_in    (pix_last_in),
        .rst_cnt_in     (rst_cnt_in),
        .bit_done_in    (bit_done_in),
        .bit_rdy_out    (bit_rdy_out),
        .bit_data_out   (bit_data_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Test controls
    stim_t stimq[$];
    int    k_dly    = 3;
    bit    b2b      = 1'b0;
    bit    stray_en = 1'b0;
    bit    rst_rand = 1'b0;
    int    rst_fixed = 10;
    int    gap_pct  = 0;

    // Model timeline: cycle numbers at which things are due
    bit    bitq[$];
    bit    m_idle = 1'b1;
    bit    m_out  = 1'b0;
    bit    m_last = 1'b0;
    bit    m_cur  = 1'b0;
    int    m_left = 0;
    int    m_rdy_at = -1;
    int    m_fd_at  = -1;
    int    m_lat_lo = -1;
    int    m_lat_hi = -1;
    int    m_idle_at = -1;

    // Coder model and logs
    bit          c_busy = 1'b0;
    int          c_done_at = -1;
    bit          accepted_prev = 1'b0;
    int          n_rdy = 0;
    int          fd_count = 0;
    int          fd_cyc = -1;
    int          last_done_cyc = -1;
    logic [95:0] cap = '0;

    task automatic clear_logs();
        n_rdy = 0; fd_count = 0; fd_cyc = -1; last_done_cyc = -1; cap = '0;
    endtask

    task automatic push_pix(input logic [PB-1:0] d, input logic l);
        stim_t s;
        s.data = d;
        s.last = l;
        stimq.push_back(s);
    endtask

    // Model, coder, stimulus driver and per-cycle compare, all at the falling edge
    initial begin
        int t;
        bit e_rdy, e_fd, e_lat;
        pix_valid_in = 1'b0; pix_data_in = '0; pix_last_in = 1'b0;
        bit_done_in = 1'b0; rst_cnt_in = '0;
        forever begin
            @(negedge clk_in);
            t = cyc;
            if (!rst_n_in) begin
                bitq.delete();
                m_idle = 1'b1; m_out = 1'b0; m_left = 0;
                m_rdy_at = -1; m_fd_at = -1; m_lat_lo = -1; m_lat_hi = -1; m_idle_at = -1;
                c_busy = 1'b0; bit_done_in = 1'b0;
            end else begin
                e_rdy = (t == m_rdy_at);
                e_fd  = (t == m_fd_at);
                e_lat = (t >= m_lat_lo) && (t <= m_lat_hi);
                if (e_rdy && bitq.size() > 0) begin
                    m_cur = bitq.pop_front();
                    m_out = 1'b1;
                end
                chk1("pix_ready", pix_ready_out, m_idle);
                chk1("busy", busy_out, !m_idle);
                chk1("bit_rdy", bit_rdy_out, e_rdy);
                chk1("frame_done", frame_done_out, e_fd);
                if (m_out) chk1("bit_data_window", bit_data_out, m_cur);
                if (e_lat) chk1("latch_data_low", bit_data_out, 1'b0);

                if (bit_rdy_out) begin
                    chk1("rdy_while_outstanding", c_busy, 1'b0);
                    c_busy = 1'b1;
                    c_done_at = t + k_dly;
                    n_rdy++;
                    cap = {cap[94:0], bit_data_out};
                end
                if (frame_done_out) begin
                    fd_count++;
                    fd_cyc = t;
                end

                bit_done_in = 1'b0;
                if (c_busy && t == c_done_at) begin
                    bit_done_in = 1'b1;
                    c_busy = 1'b0;
                    last_done_cyc = t;
                end else if (stray_en && !c_busy && (m_idle || e_lat) && $urandom_range(0, 3) == 0) begin
                    bit_done_in = 1'b1;
                end

                if (accepted_prev || !pix_valid_in) begin
                    accepted_prev = 1'b0;
                    if (stimq.size() > 0 && (b2b || $urandom_range(0, 99) >= gap_pct)) begin
                        pix_valid_in = 1'b1;
                        pix_data_in  = stimq[0].data;
                        pix_last_in  = stimq[0].last;
                    end else begin
                        pix_valid_in = 1'b0;
                        pix_data_in  = PB'($urandom);
                        pix_last_in  = 1'($urandom);
                    end
                end

                if (e_lat) rst_cnt_in = RCW'($urandom_range(0, 200));
                else if (rst_rand) rst_cnt_in = RCW'($urandom_range(0, 20));
                else rst_cnt_in = RCW'(rst_fixed);

                if (pix_valid_in && m_idle) begin
                    for (int i = int'(PB) - 1; i >= 0; i--) bitq.push_back(pix_data_in[i]);
                    m_idle = 1'b0;
                    m_rdy_at = t + 1;
                    m_left = int'(PB);
                    m_last = pix_last_in;
                    stimq.delete(0);
                    accepted_prev = 1'b1;
                end
                if (bit_done_in && m_out) begin
                    m_out = 1'b0;
                    m_left--;
                    if (m_left > 0) begin
                        m_rdy_at = t + 1;
                    end else if (m_last) begin
                        m_lat_lo  = t + 1;
                        m_lat_hi  = t + 1 + int'(rst_cnt_in);
                        m_fd_at   = m_lat_hi + 1;
                        m_idle_at = m_fd_at;
                    end else begin
                        m_idle_at = t + 1;
                    end
                end
                if (!m_idle && (t + 1 == m_idle_at)) m_idle = 1'b1;
            end
        end
    end

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (!(stimq.size() == 0 && !pix_valid_in && m_idle) && n < budget) begin
            @(posedge clk_in);
            n++;
        end
        chki({nm, "_in_time"}, int'(n < budget), 1);
        repeat (4) @(posedge clk_in);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk1({nm, "_ready"}, pix_ready_out, 1'b1);
        chk1({nm, "_bit_rdy"}, bit_rdy_out, 1'b0);
        chk1({nm, "_bit_data"}, bit_data_out, 1'b0);
        chk1({nm, "_busy"}, busy_out, 1'b0);
        chk1({nm, "_frame_done"}, frame_done_out, 1'b0);
    endtask

    initial begin
        logic [PB-1:0] p [3];
        logic [95:0]   exp_cap;
        int            n;
        int            n_last;

        rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #2;
        chk_reset_vals("por");
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);

        // Single directed pixel, latch period 10, coder delay 3
        clear_logs();
        k_dly = 3; rst_fixed = 10;
        push_pix(DIR_PIX, 1'b1);
        wait_drain("single", 2000);
        chki("single_rdy_count", n_rdy, int'(PB));
        chkv("single_bits", cap, 96'(DIR_PIX));
        chki("single_frame_done_count", fd_count, 1);
        chki("single_latch_span", fd_cyc - last_done_cyc, 12);

        // Three back-to-back pixels, valid held high, coder delay 1
        clear_logs();
        k_dly = 1; b2b = 1'b1; rst_fixed = 3;
        exp_cap = '0;
        for (int i = 0; i < 3; i++) begin
            p[i] = PB'($urandom);
            exp_cap = (exp_cap << PB) | 96'(p[i]);
            push_pix(p[i], (i == 2));
        end
        wait_drain("b2b", 3000);
        chki("b2b_rdy_count", n_rdy, 3 * int'(PB));
        chkv("b2b_bits", cap, exp_cap);
        chki("b2b_frame_done_count", fd_count, 1);
        b2b = 1'b0;

        // Zero latch count gives a single latch cycle
        clear_logs();
        k_dly = 2; rst_fixed = 0;
        push_pix(PB'($urandom), 1'b1);
        wait_drain("zero_latch", 2000);
        chki("zero_latch_span", fd_cyc - last_done_cyc, 2);
        chki("zero_latch_frame_done_count", fd_count, 1);

        // Reset while waiting on bit 10, then a fresh pixel must start from its MSB
        clear_logs();
        k_dly = 3; rst_fixed = 5;
        push_pix(PB'($urandom), 1'b1);
        n = 0;
        while (n_rdy < 10 && n < 2000) begin
            @(posedge clk_in);
            n++;
        end
        chki("reach_bit10", int'(n < 2000), 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk_reset_vals("midbit_reset");
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;
        clear_logs();
        p[0] = PB'($urandom);
        push_pix(p[0], 1'b1);
        wait_drain("after_reset", 2000);
        chkv("after_reset_bits", cap, 96'(p[0]));
        chki("after_reset_frame_done_count", fd_count, 1);

        // Randomized frames with stray done pulses and random latch counts
        stray_en = 1'b1; rst_rand = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            k_dly   = (pass == 0) ? 1 : 4;
            gap_pct = (pass == 0) ? 30 : 60;
            n_last = 0;
            for (int i = 0; i < 12; i++) begin
                logic l;
                l = (i == 11) ? 1'b1 : ($urandom_range(0, 3) == 0);
                if (l) n_last++;
                push_pix(PB'($urandom), l);
            end
            wait_drain("random", 20000);
            chki("random_rdy_count", n_rdy, 12 * int'(PB));
            chki("random_frame_done_count", fd_count, n_last);
        end
        stray_en = 1'b0; rst_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
